// File: rtl/clock_phase_gen.sv
// Multi-channel clock-enable / divided-clock generator with double-buffered per-channel
// divide and phase config. Optional per-channel stall inputs are enabled by CLKGEN_STALL_EN.
module clock_phase_gen #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2,
    parameter int CNT_W  = 4,
    parameter int DEF_DIV = 1,
    parameter logic [NUM_CH*CNT_W-1:0] DEF_PHASE_VEC = {4'd1, 4'd1, 4'd0, 4'd0}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              resync,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_phase,
`ifdef CLKGEN_STALL_EN
    input  logic [NUM_CH-1:0] stall_mask,
`endif
    output logic [NUM_CH-1:0] ce,
    output logic [NUM_CH-1:0] clk_out,
    output logic              aligned,
    output logic [NUM_CH-1:0] cfg_pending,
    output logic              cfg_err
);

    localparam logic [CH_W:0]    NUM_CH_L = (CH_W+1)'(NUM_CH);
    localparam logic [CNT_W-1:0] DEF_D    = CNT_W'(DEF_DIV);

    logic              wr_ok;
    logic [NUM_CH-1:0] stall_eff;
    logic [NUM_CH-1:0] cnt_zero;
    logic [NUM_CH-1:0] ce_hit;

`ifdef CLKGEN_STALL_EN
    assign stall_eff = stall_mask;
`else
    assign stall_eff = '0;
`endif

    // A write is accepted only for an existing channel with a phase inside its period.
    assign wr_ok = ({1'b0, cfg_ch} < NUM_CH_L) && (cfg_phase <= cfg_div);

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] div_reg;
            logic [CNT_W-1:0] phase_reg;
            logic [CNT_W-1:0] sdiv_reg;
            logic [CNT_W-1:0] sphase_reg;
            logic             pend_reg;
            logic             clk_reg;
            logic             wr_hit;
            logic             at_wrap;
            logic             advance;

            assign wr_hit  = cfg_we & wr_ok & (cfg_ch == CH_W'(gi));
            assign at_wrap = (cnt_reg >= div_reg);
            assign advance = run & ~stall_eff[gi];

            always_ff @(posedge clock) begin
                if (reset) begin
                    cnt_reg    <= '0;
                    div_reg    <= DEF_D;
                    phase_reg  <= DEF_PHASE_VEC[gi*CNT_W +: CNT_W];
                    sdiv_reg   <= DEF_D;
                    sphase_reg <= DEF_PHASE_VEC[gi*CNT_W +: CNT_W];
                    pend_reg   <= 1'b0;
                    clk_reg    <= 1'b0;
                end else begin
                    if (resync) begin
                        cnt_reg <= '0;
                        if (pend_reg) begin
                            div_reg   <= sdiv_reg;
                            phase_reg <= sphase_reg;
                            pend_reg  <= 1'b0;
                        end
                    end else if (advance) begin
                        if (at_wrap) begin
                            cnt_reg <= '0;
                            if (pend_reg) begin
                                div_reg   <= sdiv_reg;
                                phase_reg <= sphase_reg;
                                pend_reg  <= 1'b0;
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                    if (advance) begin
                        clk_reg <= (cnt_reg <= (div_reg >> 1));
                    end
                    // Placed last so a write in the apply cycle re-arms pending with the new shadow.
                    if (wr_hit) begin
                        sdiv_reg   <= cfg_div;
                        sphase_reg <= cfg_phase;
                        pend_reg   <= 1'b1;
                    end
                end
            end

            assign ce_hit[gi]      = (cnt_reg == phase_reg) & ~stall_eff[gi];
            assign cnt_zero[gi]    = (cnt_reg == '0);
            assign clk_out[gi]     = clk_reg;
            assign cfg_pending[gi] = pend_reg;
        end
    endgenerate

    assign ce      = {NUM_CH{run & ~reset}} & ce_hit;
    assign aligned = run & ~reset & (&cnt_zero);

    always_ff @(posedge clock) begin
        if (reset) begin
            cfg_err <= 1'b0;
        end else if (cfg_we && !wr_ok) begin
            cfg_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_clock_phase_gen.sv
// Self-checking bench for clock_phase_gen: directed scenarios plus randomized traffic
// compared against a period/modulo reference model.
module tb_clock_phase_gen;

    logic       clock;
    logic       reset;
    logic       run;
    logic       resync;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [3:0] cfg_div;
    logic [3:0] cfg_phase;
    logic [3:0] ce;
    logic [3:0] clk_out;
    logic       aligned;
    logic [3:0] cfg_pending;
    logic       cfg_err;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: position within period, period parameters, shadow config.
    int m_cnt[4];
    int m_d[4];
    int m_p[4];
    int m_sd[4];
    int m_sp[4];
    bit m_pend[4];
    bit m_clk[4];
    bit m_err;

    clock_phase_gen dut (
        .clock(clock), .reset(reset), .run(run), .resync(resync),
        .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_phase(cfg_phase),
        .ce(ce), .clk_out(clk_out), .aligned(aligned),
        .cfg_pending(cfg_pending), .cfg_err(cfg_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [13:0] exp_vec();
        logic [3:0] e_ce, e_clk, e_pend;
        logic e_al;
        e_al = run && !reset;
        for (int i = 0; i < 4; i++) begin
            e_ce[i]   = run && !reset && (m_cnt[i] == m_p[i]);
            e_clk[i]  = m_clk[i];
            e_pend[i] = m_pend[i];
            if (m_cnt[i] != 0) e_al = 1'b0;
        end
        return {e_ce, e_clk, e_al, e_pend, m_err};
    endfunction

    task automatic model_step();
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] = 0; m_d[i] = 1; m_p[i] = (i >= 2) ? 1 : 0;
                m_sd[i] = m_d[i]; m_sp[i] = m_p[i]; m_pend[i] = 0; m_clk[i] = 0;
            end
            m_err = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (run) m_clk[i] = (m_cnt[i] <= m_d[i] / 2);
                if (resync) begin
                    m_cnt[i] = 0;
                    if (m_pend[i]) begin m_d[i] = m_sd[i]; m_p[i] = m_sp[i]; m_pend[i] = 0; end
                end else if (run) begin
                    if (m_pend[i] && m_cnt[i] == m_d[i]) begin
                        m_d[i] = m_sd[i]; m_p[i] = m_sp[i]; m_pend[i] = 0; m_cnt[i] = 0;
                    end else begin
                        m_cnt[i] = (m_cnt[i] + 1) % (m_d[i] + 1);
                    end
                end
            end
            if (cfg_we) begin
                if (int'(cfg_ch) >= 4 || cfg_phase > cfg_div) m_err = 1;
                else begin
                    m_sd[int'(cfg_ch)] = int'(cfg_div);
                    m_sp[int'(cfg_ch)] = int'(cfg_phase);
                    m_pend[int'(cfg_ch)] = 1;
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic ru, input logic rs, input logic we,
                         input logic [1:0] ch, input logic [3:0] d, input logic [3:0] p);
        reset = r; run = ru; resync = rs; cfg_we = we; cfg_ch = ch; cfg_div = d; cfg_phase = p;
        #1;
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1, 1, 0, 0, 0, 0, 0);
            if (k == 1) begin
                vectors++;
                if ({ce, aligned, clk_out, cfg_pending, cfg_err} !== 14'd0) begin
                    miscompares++;
                    $display("FAIL reset_state got ce=%b al=%b clk=%b pend=%b err=%b want all 0",
                             ce, aligned, clk_out, cfg_pending, cfg_err);
                end
            end
            cycle();
        end
        for (int k = 0; k < 6; k++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            vectors++;
            if (ce !== ((k % 2 == 0) ? 4'b0011 : 4'b1100) || aligned !== (k % 2 == 0)
                || clk_out[0] !== (k % 2 == 1)) begin
                miscompares++;
                $display("FAIL default_pattern cyc=%0d got ce=%b al=%b clk0=%b", k, ce, aligned, clk_out[0]);
            end
            vectors++;
            if ({ce, clk_out, aligned, cfg_pending, cfg_err} !== exp_vec()) begin
                miscompares++;
                $display("FAIL default_model cyc=%0d got %b want %b", k,
                         {ce, clk_out, aligned, cfg_pending, cfg_err}, exp_vec());
            end
            cycle();
        end
    endtask

    task automatic test_cfg_apply();
        drive(0, 1, 0, 1, 2'd2, 4'd3, 4'd2);
        cycle();
        for (int k = 7; k < 16; k++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            vectors++;
            if ((k == 7 && cfg_pending[2] !== 1'b1) || (k >= 8 && cfg_pending[2] !== 1'b0)
                || (k >= 8 && ce[2] !== (k == 10 || k == 14))) begin
                miscompares++;
                $display("FAIL cfg_apply cyc=%0d got pend2=%b ce2=%b", k, cfg_pending[2], ce[2]);
            end
            vectors++;
            if ({ce, clk_out, aligned, cfg_pending, cfg_err} !== exp_vec()) begin
                miscompares++;
                $display("FAIL cfg_apply_model cyc=%0d got %b want %b", k,
                         {ce, clk_out, aligned, cfg_pending, cfg_err}, exp_vec());
            end
            cycle();
        end
    endtask

    task automatic test_cfg_err();
        drive(0, 1, 0, 1, 2'd1, 4'd3, 4'd5);
        cycle();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            vectors++;
            if (cfg_err !== 1'b1 || cfg_pending[1] !== 1'b0
                || {ce, clk_out, aligned, cfg_pending, cfg_err} !== exp_vec()) begin
                miscompares++;
                $display("FAIL cfg_err k=%0d got err=%b pend1=%b vec=%b want err=1 pend1=0 vec=%b", k,
                         cfg_err, cfg_pending[1], {ce, clk_out, aligned, cfg_pending, cfg_err}, exp_vec());
            end
            cycle();
        end
    endtask

    task automatic test_hold();
        logic [3:0] saved_clk;
        drive(0, 1, 0, 0, 0, 0, 0);
        cycle();
        saved_clk = clk_out;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            vectors++;
            if (ce !== 4'b0 || aligned !== 1'b0 || clk_out !== saved_clk) begin
                miscompares++;
                $display("FAIL hold k=%0d got ce=%b al=%b clk=%b want ce=0 al=0 clk=%b",
                         k, ce, aligned, clk_out, saved_clk);
            end
            cycle();
        end
        for (int k = 0; k < 5; k++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            vectors++;
            if ({ce, clk_out, aligned, cfg_pending, cfg_err} !== exp_vec()) begin
                miscompares++;
                $display("FAIL hold_resume k=%0d got %b want %b", k,
                         {ce, clk_out, aligned, cfg_pending, cfg_err}, exp_vec());
            end
            cycle();
        end
    endtask

    task automatic test_resync();
        drive(0, 1, 0, 1, 2'd3, 4'd7, 4'd0);
        cycle();
        drive(0, 1, 1, 0, 0, 0, 0);
        vectors++;
        if (cfg_pending[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL resync_pre got pend3=%b want 1", cfg_pending[3]);
        end
        cycle();
        for (int k = 0; k < 10; k++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            if (k == 0) begin
                vectors++;
                if (cfg_pending !== 4'b0 || aligned !== 1'b1) begin
                    miscompares++;
                    $display("FAIL resync_post got pend=%b al=%b want pend=0000 al=1", cfg_pending, aligned);
                end
            end
            vectors++;
            if ({ce, clk_out, aligned, cfg_pending, cfg_err} !== exp_vec()) begin
                miscompares++;
                $display("FAIL resync_model k=%0d got %b want %b", k,
                         {ce, clk_out, aligned, cfg_pending, cfg_err}, exp_vec());
            end
            cycle();
        end
    endtask

    task automatic test_reset_pending();
        drive(0, 1, 0, 1, 2'd0, 4'd5, 4'd0);
        cycle();
        drive(1, 1, 0, 0, 0, 0, 0);
        vectors++;
        if (cfg_pending[0] !== 1'b1 || cfg_err !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_pending_pre got pend0=%b err=%b want 1 1", cfg_pending[0], cfg_err);
        end
        cycle();
        for (int k = 0; k < 4; k++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            vectors++;
            if (cfg_pending !== 4'b0 || cfg_err !== 1'b0
                || ce !== ((k % 2 == 0) ? 4'b0011 : 4'b1100) || clk_out[0] !== (k % 2 == 1)) begin
                miscompares++;
                $display("FAIL reset_pending k=%0d got pend=%b err=%b ce=%b clk0=%b",
                         k, cfg_pending, cfg_err, ce, clk_out[0]);
            end
            cycle();
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 85),
                  ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 20),
                  2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            vectors++;
            if ({ce, clk_out, aligned, cfg_pending, cfg_err} !== exp_vec()) begin
                miscompares++;
                $display("FAIL random k=%0d got %b want %b", k,
                         {ce, clk_out, aligned, cfg_pending, cfg_err}, exp_vec());
            end
            cycle();
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_cfg_apply();
        test_cfg_err();
        test_hold();
        test_resync();
        test_reset_pending();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
